// File: rtl/sensors_avg_seq_pkg.sv
// ---------------------------------------------------------------------------
// sensors_avg_seq_pkg
// Shared definitions for the sensor averager and the baggage-drop controller:
//   - FSM state encodings (legacy-compatible localparam constants)
//   - clog2 helper usable in constant expressions
//   - sumWidth: width of the never-truncated channel sum (WIDTH + clog2(N))
// No ports (package).
// ---------------------------------------------------------------------------
package sensors_avg_seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_ACCUM  = 3'd1;
   localparam state_t S_DIV    = 3'd2;
   localparam state_t S_SMOOTH = 3'd3;
   localparam state_t S_DONE   = 3'd4;

   // Ceiling log2; clog2(1) = 0 so callers guard widths that could become zero.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

   // Width that holds the sum of n readings of w bits without overflow.
   function automatic int sumWidth(input int n, input int w);
      return w + clog2(n);
   endfunction

endpackage

// File: rtl/sensors_avg_seq_divider.sv
// ---------------------------------------------------------------------------
// sensors_avg_seq_divider  (the seq_divider of the averager)
// Fixed-latency restoring divider: quotient = dividend / divisor, unsigned.
// The first quotient bit is produced on the launch edge, the remaining W-1
// bits on the following W-1 edges, so the result is ready W cycles after a
// launch and 'done' pulses for one cycle in the cycle after the last step.
// The quotient register holds its value until the next launch.
// A zero divisor is allowed and simply yields an all-ones quotient.
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  synchronous reset, active-low
//   start     in   1  launch request (ignored while busy)
//   dividend  in   W  numerator, sampled on launch
//   divisor   in   W  denominator, sampled on launch
//   busy      out  1  division in progress
//   done      out  1  one-cycle pulse, quotient valid from this cycle
//   quotient  out  W  result
// ---------------------------------------------------------------------------
module sensors_avg_seq_divider
   import sensors_avg_seq_pkg::*;
#(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int ITER_W = clog2(W + 1);

   logic [W-1:0]      r_rem;
   logic [W-1:0]      r_quo;
   logic [W-1:0]      r_div;
   logic [ITER_W-1:0] r_iter;
   logic              r_busy;
   logic              r_done;

   logic              w_launch;
   logic [W-1:0]      w_remIn;
   logic [W-1:0]      w_quoIn;
   logic [W-1:0]      w_divIn;
   logic [W:0]        w_shifted;
   logic [W:0]        w_trial;
   logic [W-1:0]      w_remNext;
   logic [W-1:0]      w_quoNext;

   // One restoring step. On a launch the step works directly on the incoming
   // operands so the first bit costs no extra cycle. The remainder stays below
   // the divisor, so W bits hold it; the shifted value needs W+1 bits and the
   // top bit of the trial difference acts as the borrow.
   always_comb begin
      w_launch  = start && !r_busy;
      w_remIn   = w_launch ? '0 : r_rem;
      w_quoIn   = w_launch ? dividend : r_quo;
      w_divIn   = w_launch ? divisor : r_div;
      w_shifted = {w_remIn, w_quoIn[W-1]};
      w_trial   = w_shifted - {1'b0, w_divIn};
      if (!w_trial[W]) begin
         w_remNext = w_trial[W-1:0];
         w_quoNext = {w_quoIn[W-2:0], 1'b1};
      end else begin
         w_remNext = w_shifted[W-1:0];
         w_quoNext = {w_quoIn[W-2:0], 1'b0};
      end
   end

   // Iteration control: r_iter counts the steps still to do after the current one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_div  <= '0;
         r_iter <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_launch) begin
            r_rem  <= w_remNext;
            r_quo  <= w_quoNext;
            r_div  <= divisor;
            r_iter <= ITER_W'(W - 1);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_rem  <= w_remNext;
            r_quo  <= w_quoNext;
            r_iter <= r_iter - ITER_W'(1);
            if (r_iter == ITER_W'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign quotient = r_quo;

endmodule

// File: rtl/sensors_avg_seq.sv
// ---------------------------------------------------------------------------
// sensors_avg_seq
// Captures N sensor readings on a valid/ready handshake, drops zero readings
// (faulty sensors) and returns the round-half-up mean of the rest after a fixed
// accumulate/divide sequence: out_valid rises N+SUM_W+1 cycles after accept
// (one more with smoothing). One vector in flight, no input buffering.
// Optional feature macro: SENSORS_AVG_SMOOTH_EN
//   defined   -> extra SMOOTH state, DEPTH-entry moving average over results
//   undefined -> height is the rounded mean directly, DEPTH is ignored
// Parameters: N (2..16 channels), WIDTH (bits per reading/result),
//             DEPTH (smoothing window, power of two)
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous reset, active-low
//   in_valid   in   1        sensor vector valid
//   in_ready   out  1        high only in IDLE
//   sensors    in   N*WIDTH  channel k at [k*WIDTH +: WIDTH], 0 = faulty
//   out_valid  out  1        height/err valid (DONE)
//   out_ready  in   1        consumer accepts result
//   height     out  WIDTH    rounded mean of non-zero channels
//   err        out  1        all channels were zero
// ---------------------------------------------------------------------------
module sensors_avg_seq
   import sensors_avg_seq_pkg::*;
#(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] sensors,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   height,
   output logic               err
);

   localparam int SUM_W = sumWidth(N, WIDTH);
   localparam int CNT_W = clog2(N + 1);
   localparam int IDX_W = clog2(N);
   localparam logic [SUM_W-1:0] QMAX = {{(SUM_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};

`ifdef SENSORS_AVG_SMOOTH_EN
   localparam int SH    = clog2(DEPTH);
   localparam int RUN_W = WIDTH + SH;
   localparam int PTR_W = (DEPTH > 1) ? SH : 1;
`endif

   state_t             r_state;
   logic [N*WIDTH-1:0] r_snap;
   logic [IDX_W-1:0]   r_idx;
   logic [SUM_W-1:0]   r_sum;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_launched;
   logic [WIDTH-1:0]   r_height;
   logic               r_err;

   logic [WIDTH-1:0]   w_chan;
   logic [SUM_W-1:0]   w_dividend;
   logic [SUM_W-1:0]   w_divisor;
   logic               w_divStart;
   logic               w_divBusy;
   logic               w_divDone;
   logic [SUM_W-1:0]   w_quot;
   logic [WIDTH-1:0]   w_qClamped;

`ifdef SENSORS_AVG_SMOOTH_EN
   logic [WIDTH-1:0]   r_hist [DEPTH];
   logic [RUN_W-1:0]   r_runSum;
   logic [PTR_W-1:0]   r_wptr;
   logic [RUN_W-1:0]   w_newRun;
`endif

   // The snapshot is shifted down one channel per ACCUM cycle, so the
   // channel being summed is always the lowest slice.
   // Adding cnt>>1 before dividing gives round-half-up; the sum cannot
   // overflow SUM_W because N*(2^WIDTH-1)+N/2 < N*2^WIDTH <= 2^SUM_W.
   // The quotient is provably <= 2^WIDTH-1; the clamp only guards the cast.
   always_comb begin
      w_chan     = r_snap[WIDTH-1:0];
      w_dividend = r_sum + SUM_W'(r_cnt >> 1);
      w_divisor  = SUM_W'(r_cnt);
      w_divStart = (r_state == S_DIV) && !r_launched && !w_divBusy;
      w_qClamped = (w_quot > QMAX) ? {WIDTH{1'b1}} : w_quot[WIDTH-1:0];
   end

`ifdef SENSORS_AVG_SMOOTH_EN
   // Running window sum after replacing the oldest entry with the new result.
   always_comb begin
      w_newRun = r_runSum - RUN_W'(r_hist[r_wptr]) + RUN_W'(w_qClamped);
   end
`endif

   // The divider also runs when every channel was zero (divisor 0); its
   // result is then discarded. This keeps the DIV stage the same length
   // whatever the input, so the latency is constant.
   sensors_avg_seq_divider #(
      .W (SUM_W)
   ) u_divider (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (w_divStart),
      .dividend (w_dividend),
      .divisor  (w_divisor),
      .busy     (w_divBusy),
      .done     (w_divDone),
      .quotient (w_quot)
   );

   // Main sequencer: IDLE -> ACCUM (N cycles) -> DIV (SUM_W+1 cycles)
   // -> [SMOOTH] -> DONE. Reset anywhere aborts the vector with no output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_snap     <= '0;
         r_idx      <= '0;
         r_sum      <= '0;
         r_cnt      <= '0;
         r_launched <= 1'b0;
         r_height   <= '0;
         r_err      <= 1'b0;
`ifdef SENSORS_AVG_SMOOTH_EN
         r_runSum   <= '0;
         r_wptr     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_hist[i] <= '0;
         end
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_snap     <= sensors;
                  r_sum      <= '0;
                  r_cnt      <= '0;
                  r_idx      <= '0;
                  r_launched <= 1'b0;
                  r_state    <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (w_chan != '0) begin
                  r_sum <= r_sum + SUM_W'(w_chan);
                  r_cnt <= r_cnt + CNT_W'(1);
               end
               r_snap <= r_snap >> WIDTH;
               if (r_idx == IDX_W'(N - 1)) begin
                  r_state <= S_DIV;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            S_DIV: begin
               if (w_divStart) begin
                  r_launched <= 1'b1;
               end
               if (w_divDone) begin
                  r_err <= (r_cnt == '0);
`ifdef SENSORS_AVG_SMOOTH_EN
                  r_state <= S_SMOOTH;
`else
                  r_height <= (r_cnt == '0) ? '0 : w_qClamped;
                  r_state  <= S_DONE;
`endif
               end
            end
`ifdef SENSORS_AVG_SMOOTH_EN
            S_SMOOTH: begin
               // Error results bypass the window entirely.
               if (r_err) begin
                  r_height <= '0;
               end else begin
                  r_runSum       <= w_newRun;
                  r_hist[r_wptr] <= w_qClamped;
                  r_wptr         <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
                  r_height       <= WIDTH'(w_newRun >> SH);
               end
               r_state <= S_DONE;
            end
`endif
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign height    = r_height;
   assign err       = r_err;

endmodule

// File: tb/tb_sensors_avg_seq.sv
// ---------------------------------------------------------------------------
// tb_sensors_avg_seq
// Self-checking bench for sensors_avg_seq (N=4, WIDTH=8, DEPTH=4).
// Directed vectors, backpressure, reset mid-divide and randomized vectors,
// all compared against a plain-arithmetic reference model.
// Follows SENSORS_AVG_SMOOTH_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sensors_avg_seq;

   localparam int N     = 4;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
`ifdef SENSORS_AVG_SMOOTH_EN
   localparam int LAT = N + WIDTH + $clog2(N) + 2;
`else
   localparam int LAT = N + WIDTH + $clog2(N) + 1;
`endif

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [N*WIDTH-1:0] sensors;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   height;
   logic               err;

   int checksTotal  = 0;
   int checksPassed = 0;
   int smoothHist[$];

   sensors_avg_seq #(
      .N     (N),
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sensors   (sensors),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .height    (height),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checksTotal++;
      if (observed == expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: observed %0d, required %0d", tag, observed, expected);
      end
   endtask

   function automatic logic [N*WIDTH-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
      return {WIDTH'(c3), WIDTH'(c2), WIDTH'(c1), WIDTH'(c0)};
   endfunction

   // Reference mean: floor(sum/cnt + 1/2) over the non-zero channels.
   function automatic int refMean(input logic [N*WIDTH-1:0] vec, output bit isErr);
      int total;
      int count;
      int value;
      total = 0;
      count = 0;
      for (int k = 0; k < N; k++) begin
         value = int'(vec[k*WIDTH +: WIDTH]);
         if (value != 0) begin
            total += value;
            count++;
         end
      end
      isErr = (count == 0);
      if (count == 0) return 0;
      return (2 * total + count) / (2 * count);
   endfunction

   // Expected height after the optional moving-average window.
   function automatic int expectedHeight(input int q, input bit isErr);
      int acc;
      if (isErr) return 0;
`ifdef SENSORS_AVG_SMOOTH_EN
      smoothHist.push_back(q);
      if (smoothHist.size() > DEPTH) void'(smoothHist.pop_front());
      acc = 0;
      foreach (smoothHist[i]) acc += smoothHist[i];
      return acc / DEPTH;
`else
      acc = q;
      return acc;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one vector, measure latency, check result, stall, then drain.
   task automatic applyStimulus(input logic [N*WIDTH-1:0] vec, input int expQ, input bit expErr,
                                input int stall, input string tag);
      int lat;
      int expH;
      expH = expectedHeight(expQ, expErr);
      checkOutput({tag, ".inReady"}, int'(in_ready), 1);
      sensors  = vec;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      sensors  = N*WIDTH'($urandom);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid && lat < 200);
      checkOutput({tag, ".latency"}, lat, LAT);
      checkOutput({tag, ".height"}, int'(height), expH);
      checkOutput({tag, ".err"}, int'(err), int'(expErr));
      if (stall > 0) begin
         repeat (stall) tick();
         checkOutput({tag, ".stallHeight"}, int'(height), expH);
         checkOutput({tag, ".stallValid"}, int'(out_valid), 1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput({tag, ".drained"}, int'(out_valid), 0);
   endtask

   initial begin
      logic [N*WIDTH-1:0] vec;
      int  q;
      bit  isErr;
      int  rises;
      int  expH;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sensors   = '0;
      repeat (3) tick();
      checkOutput("reset.inReady", int'(in_ready), 1);
      checkOutput("reset.outValid", int'(out_valid), 0);
      checkOutput("reset.height", int'(height), 0);
      checkOutput("reset.err", int'(err), 0);
      rst_n = 1'b1;
      tick();

`ifdef SENSORS_AVG_SMOOTH_EN
      // Window fill: 40,40,40,40,80 -> 10,20,30,40,50.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(pack4(40, 40, 40, 40), 40, 1'b0, 0, "smoothFill");
      end
      applyStimulus(pack4(80, 80, 80, 80), 80, 1'b0, 0, "smoothStep");
`endif

      applyStimulus(pack4(10, 20, 30, 41), 25, 1'b0, 0, "mixed");
      applyStimulus(pack4(0, 20, 30, 41), 30, 1'b0, 2, "oneZero");
      applyStimulus(pack4(0, 0, 0, 0), 0, 1'b1, 0, "allZero");
      applyStimulus(pack4(255, 255, 255, 255), 255, 1'b0, 1, "allMax");
      applyStimulus(pack4(1, 2, 0, 0), 2, 1'b0, 0, "halfUp");

      // Backpressure: result held 20 cycles while a second vector is offered.
      expH     = expectedHeight(25, 1'b0);
      sensors  = pack4(10, 20, 30, 41);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      rises = 0;
      while (!out_valid && rises < 200) begin
         tick();
         rises++;
      end
      checkOutput("bp.reached", int'(out_valid), 1);
      for (int c = 0; c < 20; c++) begin
         in_valid = (c >= 5 && c < 10);
         sensors  = pack4(1, 1, 1, 1);
         tick();
         checkOutput("bp.height", int'(height), expH);
         checkOutput("bp.inReady", int'(in_ready), 0);
         checkOutput("bp.outValid", int'(out_valid), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("bp.drained", int'(out_valid), 0);
      checkOutput("bp.idle", int'(in_ready), 1);
      rises = 0;
      repeat (LAT + 5) begin
         tick();
         if (out_valid) rises++;
      end
      checkOutput("bp.noSecondResult", rises, 0);

      // Reset while the divider is running: no result may appear.
      sensors  = pack4(10, 20, 30, 41);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (N + 3) tick();
      rst_n = 1'b0;
      tick();
      checkOutput("rstDiv.outValid", int'(out_valid), 0);
      checkOutput("rstDiv.inReady", int'(in_ready), 1);
      checkOutput("rstDiv.height", int'(height), 0);
      rst_n = 1'b1;
      smoothHist.delete();
      rises = 0;
      repeat (LAT + 5) begin
         tick();
         if (out_valid) rises++;
      end
      checkOutput("rstDiv.noResult", rises, 0);
      applyStimulus(pack4(8, 8, 8, 8), 8, 1'b0, 0, "afterReset");

      // Randomized vectors; roughly a quarter of channels read as faulty.
      for (int t = 0; t < 30; t++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0 || t % 10 == 9) vec[k*WIDTH +: WIDTH] = '0;
            else vec[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, 255));
         end
         q = refMean(vec, isErr);
         applyStimulus(vec, q, isErr, int'($urandom_range(0, 3)), "random");
      end

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
